// File: rtl/pixel_coord_generator.sv
// Raster-order pixel coordinate source for the ray generator: Q11.21 x/y over valid/ready.
// Optional macro PIXEL_CENTER_OFFSET_EN adds +0.5 pixel to every emitted coordinate.
module pixel_coord_generator #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int FRAC_BITS     = 21
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        ready_in,
    output logic [31:0] screen_x,
    output logic [31:0] screen_y,
    output logic        valid_out,
    output logic        sof,
    output logic        eol,
    output logic        busy,
    output logic        frame_done
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [10:0] X_LAST = 11'(SCREEN_WIDTH - 1);
    localparam logic [10:0] Y_LAST = 11'(SCREEN_HEIGHT - 1);

`ifdef PIXEL_CENTER_OFFSET_EN
    localparam logic [31:0] COORD_OFFSET = 32'(1) << (FRAC_BITS - 1);
`else
    localparam logic [31:0] COORD_OFFSET = 32'd0;
`endif

    function automatic logic [31:0] to_fixed(input logic [10:0] c);
        return (32'(c) << FRAC_BITS) + COORD_OFFSET;
    endfunction

    logic [1:0]  state_q, state_d;
    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic [31:0] screen_x_q, screen_x_d;
    logic [31:0] screen_y_q, screen_y_d;
    logic        valid_q, valid_d;
    logic        sof_q, sof_d;
    logic        eol_q, eol_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        xfer;
    logic        last_pixel;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        xfer       = valid_q && ready_in;
        last_pixel = (x_q == X_LAST) && (y_q == Y_LAST);

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_SCAN;
                    x_d     = '0;
                    y_d     = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ST_SCAN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    x_d     = '0;
                    y_d     = '0;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (xfer) begin
                    if (last_pixel) begin
                        state_d = ST_DONE;
                        x_d     = '0;
                        y_d     = '0;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (x_q == X_LAST) begin
                        x_d = '0;
                        y_d = y_q + 11'd1;
                    end else begin
                        x_d = x_q + 11'd1;
                    end
                end
            end
            ST_DONE: begin
                // frame_done is visible for exactly this one cycle; abort here changes nothing
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                x_d     = '0;
                y_d     = '0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        // Outputs are derived from the next counter values so a stalled beat holds naturally
        screen_x_d = valid_d ? to_fixed(x_d) : 32'd0;
        screen_y_d = valid_d ? to_fixed(y_d) : 32'd0;
        sof_d      = valid_d && (x_d == 11'd0) && (y_d == 11'd0);
        eol_d      = valid_d && (x_d == X_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            screen_x_q <= '0;
            screen_y_q <= '0;
            valid_q    <= 1'b0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            screen_x_q <= screen_x_d;
            screen_y_q <= screen_y_d;
            valid_q    <= valid_d;
            sof_q      <= sof_d;
            eol_q      <= eol_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign screen_x   = screen_x_q;
    assign screen_y   = screen_y_q;
    assign valid_out  = valid_q;
    assign sof        = sof_q;
    assign eol        = eol_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_pixel_coord_generator.sv
// Self-checking bench for pixel_coord_generator: 4x3, 1x1 and 640x2 instances against a raster model.
module tb_pixel_coord_generator;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int WB = 640;
    localparam int HB = 2;

`ifdef PIXEL_CENTER_OFFSET_EN
    localparam logic [31:0] OFS = 32'h0010_0000;
`else
    localparam logic [31:0] OFS = 32'h0000_0000;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // 4x3 instance
    logic start = 1'b0, abort = 1'b0, ready_in = 1'b0;
    logic [31:0] sx, sy;
    logic vo, so, eo, bo, fd;
    logic [68:0] obs;
    assign obs = {vo, so, eo, bo, fd, sx, sy};

    pixel_coord_generator #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .FRAC_BITS(21)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .ready_in(ready_in),
        .screen_x(sx), .screen_y(sy), .valid_out(vo), .sof(so), .eol(eo),
        .busy(bo), .frame_done(fd)
    );

    // 1x1 instance
    logic start1 = 1'b0, abort1 = 1'b0, ready1 = 1'b0;
    logic [31:0] sx1, sy1;
    logic vo1, so1, eo1, bo1, fd1;
    logic [68:0] obs1;
    assign obs1 = {vo1, so1, eo1, bo1, fd1, sx1, sy1};

    pixel_coord_generator #(.SCREEN_WIDTH(1), .SCREEN_HEIGHT(1), .FRAC_BITS(21)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .ready_in(ready1),
        .screen_x(sx1), .screen_y(sy1), .valid_out(vo1), .sof(so1), .eol(eo1),
        .busy(bo1), .frame_done(fd1)
    );

    // 640x2 instance
    logic start2 = 1'b0, abort2 = 1'b0, ready2 = 1'b0;
    logic [31:0] sx2, sy2;
    logic vo2, so2, eo2, bo2, fd2;
    logic [68:0] obs2;
    assign obs2 = {vo2, so2, eo2, bo2, fd2, sx2, sy2};

    pixel_coord_generator #(.SCREEN_WIDTH(WB), .SCREEN_HEIGHT(HB), .FRAC_BITS(21)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2), .ready_in(ready2),
        .screen_x(sx2), .screen_y(sy2), .valid_out(vo2), .sof(so2), .eol(eo2),
        .busy(bo2), .frame_done(fd2)
    );

    // Reference: pixel n of a w-wide frame sits at (n % w, n / w), each scaled by 2^21
    function automatic logic [31:0] fx(input int c);
        return 32'(c) * 32'h0020_0000 + OFS;
    endfunction

    function automatic logic [68:0] beat(input int n, input int w);
        logic [68:0] r;
        r = {1'b1, 1'(n == 0), 1'((n % w) == w - 1), 1'b1, 1'b0, fx(n % w), fx(n / w)};
        return r;
    endfunction

    localparam logic [68:0] IDLE_OBS = 69'h0;
    localparam logic [68:0] DONE_OBS = {5'b00001, 64'h0};

    task automatic test_reset();
        #3;
        checks++;
        if (obs !== IDLE_OBS) begin failures++; $display("FAIL reset_4x3 got %h exp %h", obs, IDLE_OBS); end
        checks++;
        if (obs1 !== IDLE_OBS) begin failures++; $display("FAIL reset_1x1 got %h exp %h", obs1, IDLE_OBS); end
        checks++;
        if (obs2 !== IDLE_OBS) begin failures++; $display("FAIL reset_640x2 got %h exp %h", obs2, IDLE_OBS); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Runs one full 4x3 frame; optionally random ready and stray start pulses mid-frame
    task automatic run_frame(input string name, input bit rand_ready, input bit poke_start);
        int idx;
        int cyc;
        bit stalled;
        logic [68:0] prev;
        idx = 0; cyc = 0; stalled = 1'b0; prev = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (idx < W * H && cyc < 500) begin
            checks++;
            if (obs !== beat(idx, W)) begin
                failures++;
                $display("FAIL %s beat %0d got %h exp %h", name, idx, obs, beat(idx, W));
            end
            if (stalled) begin
                checks++;
                if (obs !== prev) begin
                    failures++;
                    $display("FAIL %s hold beat %0d got %h exp %h", name, idx, obs, prev);
                end
            end
            prev = obs;
            ready_in = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            start = poke_start ? 1'($urandom_range(0, 3) == 0) : 1'b0;
            stalled = !ready_in;
            if (ready_in) idx++;
            @(negedge clk);
            cyc++;
        end
        ready_in = 1'b0;
        start = poke_start;
        checks++;
        if (cyc >= 500) begin failures++; $display("FAIL %s timeout beats=%0d exp %0d", name, idx, W * H); end
        checks++;
        if (obs !== DONE_OBS) begin failures++; $display("FAIL %s done got %h exp %h", name, obs, DONE_OBS); end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (obs !== IDLE_OBS) begin failures++; $display("FAIL %s post_done got %h exp %h", name, obs, IDLE_OBS); end
    endtask

    task automatic test_stream();
        run_frame("stream_4x3", 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 3; i++) run_frame("backpressure_4x3", 1'b1, 1'b0);
    endtask

    task automatic test_start_while_busy();
        run_frame("start_in_scan", 1'b1, 1'b1);
    endtask

    task automatic test_abort();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ready_in = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (obs !== beat(5, W)) begin failures++; $display("FAIL abort_pre got %h exp %h", obs, beat(5, W)); end
        ready_in = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs !== IDLE_OBS) begin failures++; $display("FAIL abort_idle cyc %0d got %h exp %h", i, obs, IDLE_OBS); end
            @(negedge clk);
        end
        run_frame("restart_after_abort", 1'b0, 1'b0);
    endtask

    task automatic test_start_abort_idle();
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs !== IDLE_OBS) begin failures++; $display("FAIL start_abort_idle cyc %0d got %h exp %h", i, obs, IDLE_OBS); end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ready_in = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs !== IDLE_OBS) begin failures++; $display("FAIL async_reset got %h exp %h", obs, IDLE_OBS); end
        @(negedge clk);
        rst = 1'b0;
        ready_in = 1'b0;
        @(negedge clk);
        run_frame("after_reset", 1'b1, 1'b0);
    endtask

    task automatic test_one_by_one();
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        ready1 = 1'b0;
        @(negedge clk);
        checks++;
        if (obs1 !== beat(0, 1)) begin failures++; $display("FAIL 1x1_beat got %h exp %h", obs1, beat(0, 1)); end
        ready1 = 1'b1;
        @(negedge clk);
        ready1 = 1'b0;
        checks++;
        if (obs1 !== DONE_OBS) begin failures++; $display("FAIL 1x1_done got %h exp %h", obs1, DONE_OBS); end
        @(negedge clk);
        checks++;
        if (obs1 !== IDLE_OBS) begin failures++; $display("FAIL 1x1_idle got %h exp %h", obs1, IDLE_OBS); end
    endtask

    task automatic test_wide_rows();
        int idx;
        int cyc;
        idx = 0; cyc = 0;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        ready2 = 1'b1;
        while (vo2 && cyc < 2000) begin
            checks++;
            if (obs2 !== beat(idx, WB)) begin
                failures++;
                $display("FAIL wide_beat %0d got %h exp %h", idx, obs2, beat(idx, WB));
            end
            idx++;
            @(negedge clk);
            cyc++;
        end
        ready2 = 1'b0;
        checks++;
        if (idx != WB * HB) begin failures++; $display("FAIL wide_count got %0d exp %0d", idx, WB * HB); end
        checks++;
        if (obs2 !== DONE_OBS) begin failures++; $display("FAIL wide_done got %h exp %h", obs2, DONE_OBS); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_start_while_busy();
        test_abort();
        test_start_abort_idle();
        test_async_reset();
        test_one_by_one();
        test_wide_rows();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pixel_coord_generator.md
Name: pixel_coord_generator

Overview:
- Frame-scan source that drives the coordinate input side of ray_generator: screen_x, screen_y, valid_in.
- Walks every pixel of a SCREEN_WIDTH x SCREEN_HEIGHT frame in raster order, left to right, then top to bottom.
- Emits each coordinate as Q11.21 fixed point over a valid/ready handshake with full backpressure.
- Sits between the frame/host control logic and the ray-march pipeline front end.

Parameters:
- SCREEN_WIDTH, 640, pixels per row; range 1..2047.
- SCREEN_HEIGHT, 480, rows per frame; range 1..2047.
- FRAC_BITS, 21, fractional bits of the emitted coordinates (Q11.21).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- abort  in  1  synchronous; cancels the frame in progress.
- ready_in  in  1  downstream can accept a coordinate this cycle.
- screen_x  out  32  pixel x, Q11.21: x << FRAC_BITS.
- screen_y  out  32  pixel y, Q11.21: y << FRAC_BITS.
- valid_out  out  1  screen_x/screen_y hold a valid pixel; connects to ray_generator valid_in.
- sof  out  1  current beat is pixel (0,0).
- eol  out  1  current beat is the last pixel of its row.
- busy  out  1  a frame is in progress.
- frame_done  out  1  one-cycle pulse after the final pixel is accepted.

Behaviour:
- Reset values: screen_x=0, screen_y=0, valid_out=0, sof=0, eol=0, busy=0, frame_done=0, state=IDLE. Reset takes effect immediately and asynchronously, including mid-frame.
- State machine IDLE / SCAN / DONE.
  - IDLE: start && !abort -> SCAN. Next cycle presents valid_out=1, x=0, y=0, sof=1, busy=1.
  - SCAN: a transfer occurs on valid_out && ready_in.
    - On a transfer that is not the last pixel, advance x. When x==SCREEN_WIDTH-1, x wraps to 0 and y increments.
    - The next pixel is presented the following cycle. With ready_in held high, there is no bubble: one pixel per clock.
    - On the transfer of pixel (SCREEN_WIDTH-1, SCREEN_HEIGHT-1): valid_out=0 next cycle, go to DONE.
  - DONE: frame_done=1 for exactly one cycle, busy=0, then IDLE.
- Backpressure: while valid_out && !ready_in, screen_x, screen_y, sof and eol hold stable and valid_out stays 1. The generator never retracts valid_out without a transfer, except on abort or reset.
- Coordinates are held in internal 11-bit counters. Outputs are registered as counter << FRAC_BITS, zero-extended to 32 bits. Upper bits beyond bit 31 are not possible for the legal range.
- eol = (x == SCREEN_WIDTH-1) on the presented beat. sof = (x==0 && y==0).
- start while busy or in DONE: ignored; the frame continues unchanged.
- abort in SCAN or DONE: next cycle valid_out=0, busy=0, counters cleared, state IDLE, no frame_done. abort in IDLE: no effect.
- start and abort in the same cycle: abort wins.
- Degenerate 1x1 frame: the single beat has sof=1 and eol=1; DONE follows its transfer.
- Latency: start to first valid_out is 1 cycle. Last transfer to frame_done is 1 cycle.
- Pixel count per frame is exactly SCREEN_WIDTH*SCREEN_HEIGHT transfers.

Optional Feature:
- Macro: PIXEL_CENTER_OFFSET_EN.
- Defined: every emitted coordinate gets +0.5 pixel, i.e. 1 << (FRAC_BITS-1) = 0x00100000 at FRAC_BITS=21, added to both screen_x and screen_y. Rays then sample pixel centres. Pixel (0,0) emits 0x00100000/0x00100000.
- Not defined: integer pixel corners; pixel (0,0) emits 0x00000000/0x00000000.
- Counter, handshake and timing behaviour are identical in both builds.

Test Plan:
- Default params, start pulse, ready_in=1 -> first beat (0x00000000, 0x00000000) with sof=1. Exactly 307200 transfers, one per clock. Last beat (0x4FE00000, 0x3BE00000) with eol=1. frame_done pulses 1 cycle later.
- SCREEN_WIDTH=4, SCREEN_HEIGHT=3, ready_in=1 -> beat (3,0) = (0x00600000, 0x00000000) with eol=1. Next beat is (0x00000000, 0x00200000).
- W=4, H=3, ready_in toggled pseudo-randomly -> every beat held stable while stalled. 12 unique beats in raster order, none dropped or duplicated.
- Abort asserted after the 5th transfer of a 4x3 frame -> valid_out=0 and busy=0 next cycle, no frame_done. A new start restarts at (0,0).
- start during SCAN and start+abort together in IDLE -> both ignored; the frame sequence and state are unchanged.
- rst asserted mid-frame, asynchronously between clock edges -> all outputs 0 immediately. With PIXEL_CENTER_OFFSET_EN defined, the next frame's first beat is (0x00100000, 0x00100000).
